// File: rtl/elevator_pkg.sv
// Shared types and constants for the lift call scheduler: floor geometry defaults,
// scheduler state encoding and sweep-direction constants.
package elevator_pkg;
  localparam int NFLOORS_DEF = 8;
  localparam int FLOOR_W_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2,
    S_SERVE  = 2'd3
  } sched_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Scheduler <-> buttons/lift FSM bundle. master = lift/button side, slave = scheduler.
interface elevator_call_scheduler_if #(
  parameter int NFLOORS = 8,
  parameter int FLOOR_W = 3
);
  logic [NFLOORS-1:0] call_req;
  logic [FLOOR_W-1:0] cur_floor;
  logic               car_idle;
  logic               tgt_ack;
  logic               arrive;
  logic [FLOOR_W-1:0] tgt_floor;
  logic               tgt_valid;
  logic               dir_up;
  logic [NFLOORS-1:0] pending;
  logic               busy;
  logic               fault;

  modport master (
    output call_req, cur_floor, car_idle, tgt_ack, arrive,
    input  tgt_floor, tgt_valid, dir_up, pending, busy, fault
  );

  modport slave (
    input  call_req, cur_floor, car_idle, tgt_ack, arrive,
    output tgt_floor, tgt_valid, dir_up, pending, busy, fault
  );
endinterface

// File: rtl/elevator_call_select.sv
// Combinational SCAN picker: nearest pending floor ahead in the sweep direction,
// else nearest behind (direction flips), else the current floor itself.
module elevator_call_select
  import elevator_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF,
  parameter int FLOOR_W = FLOOR_W_DEF
) (
  input  logic [NFLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0] cur_floor_i,
  input  logic               dir_up_i,
  output logic [FLOOR_W-1:0] sel_floor_o,
  output logic               sel_dir_o,
  output logic               sel_found_o
);
  logic               cur_ok;
  logic               up_found, dn_found, here_found;
  logic [FLOOR_W-1:0] up_fl, dn_fl;

  assign cur_ok = ({1'b0, cur_floor_i} < (FLOOR_W+1)'(NFLOORS));

  // Descending scan leaves the lowest floor above; ascending scan leaves the highest below.
  always_comb begin
    up_found = 1'b0;
    up_fl    = '0;
    dn_found = 1'b0;
    dn_fl    = '0;
    for (int i = NFLOORS-1; i >= 0; i--) begin
      if (cur_ok && pending_i[i] && (FLOOR_W'(i) > cur_floor_i)) begin
        up_found = 1'b1;
        up_fl    = FLOOR_W'(i);
      end
    end
    for (int j = 0; j < NFLOORS; j++) begin
      if (cur_ok && pending_i[j] && (FLOOR_W'(j) < cur_floor_i)) begin
        dn_found = 1'b1;
        dn_fl    = FLOOR_W'(j);
      end
    end
  end

  assign here_found = cur_ok && pending_i[cur_floor_i];

  always_comb begin
    sel_floor_o = cur_floor_i;
    sel_found_o = here_found;
    sel_dir_o   = ~dir_up_i;
    if (dir_up_i == DIR_UP) begin
      if (up_found) begin
        sel_floor_o = up_fl;
        sel_dir_o   = DIR_UP;
        sel_found_o = 1'b1;
      end else if (dn_found) begin
        sel_floor_o = dn_fl;
        sel_dir_o   = DIR_DOWN;
        sel_found_o = 1'b1;
      end
    end else begin
      if (dn_found) begin
        sel_floor_o = dn_fl;
        sel_dir_o   = DIR_DOWN;
        sel_found_o = 1'b1;
      end else if (up_found) begin
        sel_floor_o = up_fl;
        sel_dir_o   = DIR_UP;
        sel_found_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) lift call scheduler: latches calls, picks a target, offers it over
// valid/ack and clears calls on arrival. ELEV_SCHED_WATCHDOG_EN adds an arrival watchdog.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NFLOORS = NFLOORS_DEF,
  parameter int FLOOR_W = FLOOR_W_DEF,
  parameter int TIMEOUT = 127
) (
  input logic clk_i,
  input logic rst_ni,
  elevator_call_scheduler_if.slave bus
);
  sched_state_e       state_q, state_d;
  logic [NFLOORS-1:0] pend_q, pend_d, clr_arr, clr_wd;
  logic [FLOOR_W-1:0] tgt_q, tgt_d, sel_floor;
  logic               dir_q, dir_d, sel_dir, sel_found;
  logic               cur_ok, wd_to;

  assign cur_ok = ({1'b0, bus.cur_floor} < (FLOOR_W+1)'(NFLOORS));

  always_comb begin
    clr_arr = '0;
    if (bus.arrive && cur_ok) clr_arr[bus.cur_floor] = 1'b1;
  end

`ifdef ELEV_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT+1);
  logic [WD_W-1:0] wd_q;
  logic            fault_q;

  // An arrival on the expiry cycle wins, so the timeout never fires alongside arrive.
  assign wd_to = (state_q == S_SERVE) && !bus.arrive && (wd_q == WD_W'(TIMEOUT-1));

  always_comb begin
    clr_wd = '0;
    if (wd_to) clr_wd[tgt_q] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == S_ISSUE && bus.tgt_ack) wd_q <= '0;
      else if (state_q == S_SERVE)           wd_q <= wd_q + 1'b1;
      if (wd_to) fault_q <= 1'b1;
    end
  end

  assign bus.fault = fault_q;
`else
  assign wd_to     = 1'b0;
  assign clr_wd    = '0;
  assign bus.fault = 1'b0;
`endif

  // Clear beats set when a call and an arrival hit the same floor together.
  assign pend_d = (pend_q | bus.call_req) & ~(clr_arr | clr_wd);

  elevator_call_select #(
    .NFLOORS (NFLOORS),
    .FLOOR_W (FLOOR_W)
  ) u_select (
    .pending_i   (pend_q),
    .cur_floor_i (bus.cur_floor),
    .dir_up_i    (dir_q),
    .sel_floor_o (sel_floor),
    .sel_dir_o   (sel_dir),
    .sel_found_o (sel_found)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE:   if (|pend_q && bus.car_idle) state_d = S_SELECT;
      S_SELECT: begin
        // A same-cycle arrival may have emptied the call set; nothing left to offer.
        if (pend_d == '0 || !sel_found) begin
          state_d = S_IDLE;
        end else begin
          tgt_d   = sel_floor;
          dir_d   = sel_dir;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:  if (bus.tgt_ack) state_d = S_SERVE;
      S_SERVE:  if (bus.arrive || wd_to) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      tgt_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.tgt_floor = tgt_q;
  assign bus.tgt_valid = (state_q == S_ISSUE);
  assign bus.dir_up    = dir_q;
  assign bus.pending   = pend_q;
  assign bus.busy      = (state_q != S_IDLE);
endmodule
